// File: rtl/ref_block_loader_if.sv
// Pixel stream, block status and column readout bundle for ref_block_loader.
// The loader uses the slave modport; the pixel source and consumer use master.
interface ref_block_loader_if #(
   parameter int BLK_DIM = 15,
   parameter int PIX_W   = 8
);
   logic                     in_valid;
   logic                     in_sof;
   logic [PIX_W-1:0]         in_pixel;
   logic                     in_ready;
   logic                     blk_done;
   logic                     blk_ready;
   logic                     blk_release;
   logic [3:0]               rd_col;
   logic [BLK_DIM*PIX_W-1:0] rd_col_data;
   logic                     sof_err;

   modport master (
      output in_valid, in_sof, in_pixel, blk_release, rd_col,
      input  in_ready, blk_done, blk_ready, rd_col_data, sof_err
   );

   modport slave (
      input  in_valid, in_sof, in_pixel, blk_release, rd_col,
      output in_ready, blk_done, blk_ready, rd_col_data, sof_err
   );
endinterface

// File: rtl/ref_block_loader.sv
// Raster writer and column reader for the BLK_DIM x BLK_DIM reference block.
// Optional macro SOF_RESYNC_EN: a mid-block SOF restarts the block, pulses sof_err.
module ref_block_loader #(
   parameter int BLK_DIM = 15,
   parameter int PIX_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   ref_block_loader_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

   localparam logic [3:0] LAST = 4'(BLK_DIM - 1);
   localparam logic [4:0] DIM5 = 5'(BLK_DIM);

   state_t                   state_q, state_d;
   logic [3:0]               row_q, row_d;
   logic [3:0]               col_q, col_d;
   logic                     rdy_en_q;
   logic                     rdy;
   logic                     acc;
   logic                     restart;
   logic                     we;
   logic [3:0]               wr_row, wr_col;
   logic                     done_d, done_q;
   logic                     col_ok;
   logic [BLK_DIM*PIX_W-1:0] rd_d, rd_q;
   logic [PIX_W-1:0]         mem_q [BLK_DIM][BLK_DIM];

   assign rdy          = rdy_en_q && (state_q != FULL);
   assign acc          = bus.in_valid && rdy;
   assign bus.in_ready = rdy;
   assign bus.blk_ready = (state_q == FULL);
   assign bus.blk_done  = done_q;
   assign bus.rd_col_data = rd_q;

`ifdef SOF_RESYNC_EN
   logic err_q;

   assign restart     = acc && bus.in_sof && (state_q == LOAD);
   assign bus.sof_err = err_q;

   // one-cycle flag after a block restarted on a mid-block SOF
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) err_q <= 1'b0;
      else        err_q <= restart;
   end
`else
   assign restart     = 1'b0;
   assign bus.sof_err = 1'b0;
`endif

   // state and raster position registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   // next state and raster position advance
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      unique case (state_q)
         IDLE: begin
            if (acc && bus.in_sof) begin
               state_d = LOAD;
               row_d   = 4'd0;
               col_d   = 4'd1;
            end
         end
         LOAD: begin
            if (restart) begin
               row_d = 4'd0;
               col_d = 4'd1;
            end else if (acc) begin
               if (col_q == LAST) begin
                  col_d = 4'd0;
                  if (row_q == LAST) begin
                     row_d   = 4'd0;
                     state_d = FULL;
                  end else begin
                     row_d = row_q + 4'd1;
                  end
               end else begin
                  col_d = col_q + 4'd1;
               end
            end
         end
         FULL: begin
            if (bus.blk_release) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // buffer write strobe/address and completion pulse request
   always_comb begin
      we     = 1'b0;
      wr_row = row_q;
      wr_col = col_q;
      done_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (acc && bus.in_sof) begin
               we     = 1'b1;
               wr_row = 4'd0;
               wr_col = 4'd0;
            end
         end
         LOAD: begin
            if (restart) begin
               we     = 1'b1;
               wr_row = 4'd0;
               wr_col = 4'd0;
            end else if (acc) begin
               we     = 1'b1;
               done_d = (row_q == LAST) && (col_q == LAST);
            end
         end
         default: ;
      endcase
   end

   // ready comes up one clock after reset release; done is a one-cycle pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_en_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         rdy_en_q <= 1'b1;
         done_q   <= done_d;
      end
   end

   // pixel buffer; contents survive reset
   always_ff @(posedge clk) begin
      if (we) mem_q[wr_row][wr_col] <= bus.in_pixel;
   end

   assign col_ok = ({1'b0, bus.rd_col} < DIM5);

   for (genvar r = 0; r < BLK_DIM; r++) begin : g_lane
      assign rd_d[r*PIX_W +: PIX_W] = col_ok ? mem_q[r][bus.rd_col] : '0;
   end

   // registered column readout
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_q <= '0;
      else        rd_q <= rd_d;
   end
endmodule
